// File: rtl/arvi_mdu_pkg.sv
// arvi_mdu_pkg -- shared types for the EX-stage multiply/divide unit.
//   state_e      : controller states (IDLE / BUSY / DONE)
//   F3_*         : RV32M funct3 encodings
//   op_class_t   : per-op decode (is_div, is_signed_a, is_signed_b)
//   op_class()   : funct3 -> op_class_t
package arvi_mdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef struct packed {
    logic is_div;
    logic is_signed_a;
    logic is_signed_b;
  } op_class_t;

  // MUL is treated as unsigned: the low half of the product does not
  // depend on operand signedness.
  function automatic op_class_t op_class(input logic [2:0] f3);
    op_class_t c;
    c.is_div = f3[2];
    unique case (f3)
      F3_MULH, F3_DIV, F3_REM: begin
        c.is_signed_a = 1'b1;
        c.is_signed_b = 1'b1;
      end
      F3_MULHSU: begin
        c.is_signed_a = 1'b1;
        c.is_signed_b = 1'b0;
      end
      default: begin
        c.is_signed_a = 1'b0;
        c.is_signed_b = 1'b0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep -- one combinational restoring-division step on magnitudes.
//   rem      : partial remainder (always < dvs)
//   quo      : dividend bits still to be shifted in (MSB first); quotient
//              bits are shifted in at the LSB
//   dvs      : divisor magnitude
//   rem_next : partial remainder after this step
//   quo_next : quo shifted left with the new quotient bit at the LSB
module mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          fits;

  // trial < 2*dvs, so the MSB of the XLEN+1 bit difference is a valid borrow.
  assign trial    = {rem, quo[XLEN-1]};
  assign diff     = trial - {1'b0, dvs};
  assign fits     = ~diff[XLEN];
  assign rem_next = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu -- iterative RV M-extension multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle on operand
// magnitudes, with the sign applied when the result is finalised.
// Build option: ARVI_MDU_DIV_EN -- when defined the divider is present;
// otherwise DIV/DIVU/REM/REMU complete at once with o_illegal=1, o_res=0.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-low reset
//   i_valid        : request from EX; accepted when o_ready && !i_kill
//   o_ready        : idle, can accept
//   i_f3           : RV M funct3
//   i_rs1, i_rs2   : operands (captured at acceptance)
//   i_kill         : flush; abandons any operation
//   o_valid        : one-cycle result strobe
//   o_res          : result, held until the next o_valid
//   o_illegal      : op not available in this build (qualified by o_valid)
//   o_stall        : EX-stage hold request (i_valid && !o_valid)
module ex_mdu
  import arvi_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_res,
  output logic            o_illegal,
  output logic            o_stall
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_e            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   opa_q;     // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] acc_q;     // {hi, lo}: product, or {remainder, quotient}
  logic              neg_q;     // negate product / quotient
  logic [XLEN-1:0]   fin_q;     // result presented while in DONE
  logic [XLEN-1:0]   res_q;     // last delivered result
  logic              ill_q;

  // ---------------- acceptance decode ----------------
  op_class_t       cls;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            accept;

  assign cls     = op_class(i_f3);
  assign rs1_neg = cls.is_signed_a & i_rs1[XLEN-1];
  assign rs2_neg = cls.is_signed_b & i_rs2[XLEN-1];
  assign mag1    = rs1_neg ? -i_rs1 : i_rs1;
  assign mag2    = rs2_neg ? -i_rs2 : i_rs2;
  assign accept  = i_valid & ~i_kill;

  // ---------------- multiply step ----------------
  // The multiplier sits in acc_q[lo] and is consumed from bit 0 while the
  // partial product shifts down into the vacated positions.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_prod;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod = neg_q ? -mul_next : mul_next;

  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   fin_next;

`ifdef ARVI_MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              neg_rem_q;
  logic [XLEN-1:0]   rem_n, quo_n;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res;

  mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem      (acc_q[2*XLEN-1:XLEN]),
    .quo      (acc_q[XLEN-1:0]),
    .dvs      (opa_q),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  assign div_zero = cls.is_div & (i_rs2 == '0);
  assign div_ovf  = cls.is_div & ~i_f3[0] & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
  // i_f3[1] selects the remainder.
  assign fast_res = div_zero ? (i_f3[1] ? i_rs1 : '1)
                             : (i_f3[1] ? '0    : i_rs1);

  assign acc_next = f3_q[2] ? {rem_n, quo_n} : mul_next;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    fin_next = mul_prod[XLEN-1:0];
    if (f3_q[2]) begin
      if (f3_q[1]) fin_next = neg_rem_q ? -rem_n : rem_n;
      else         fin_next = neg_q     ? -quo_n : quo_n;
    end else if (f3_q != F3_MUL) begin
      fin_next = mul_prod[2*XLEN-1:XLEN];
    end
  end
`else
  assign acc_next = mul_next;

  always_comb begin
    fin_next = mul_prod[XLEN-1:0];
    if (f3_q != F3_MUL) fin_next = mul_prod[2*XLEN-1:XLEN];
  end
`endif

  // ---------------- controller ----------------
  // NOTE: operand/accumulator registers are not reset: they are always
  // loaded at acceptance before anything reads them.
  always_ff @(posedge i_clk) begin
    if (accept && state == ST_IDLE) begin
      f3_q  <= i_f3;
      opa_q <= mag2;
      acc_q <= {{XLEN{1'b0}}, mag1};
      neg_q <= rs1_neg ^ rs2_neg;
`ifdef ARVI_MDU_DIV_EN
      neg_rem_q <= rs1_neg;
`endif
    end else if (state == ST_BUSY) begin
      acc_q <= acc_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      fin_q <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            ill_q <= 1'b0;
            state <= ST_BUSY;
`ifdef ARVI_MDU_DIV_EN
            if (div_zero || div_ovf) begin
              fin_q <= fast_res;
              state <= ST_DONE;
            end
`else
            if (cls.is_div) begin
              fin_q <= '0;
              ill_q <= 1'b1;
              state <= ST_DONE;
            end
`endif
          end
        end
        ST_BUSY: begin
          if (i_kill) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              fin_q <= fin_next;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (!i_kill) res_q <= fin_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A kill during DONE must hide the strobe and keep the old result
  // visible, so the strobe and result mux are gated by i_kill here.
  assign o_ready   = (state == ST_IDLE);
  assign o_valid   = (state == ST_DONE) & ~i_kill;
  assign o_res     = o_valid ? fin_q : res_q;
  assign o_illegal = o_valid & ill_q;
  assign o_stall   = i_valid & ~o_valid;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu -- self-checking bench for ex_mdu (XLEN=32): directed cases,
// flush/reset interruptions and randomized ops against an arithmetic model.
module tb_ex_mdu;

  localparam int XLEN = 32;
  localparam int MAX_WAIT = 40;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_f3;
  logic [XLEN-1:0] i_rs1, i_rs2;
  logic            i_kill;
  logic            o_valid;
  logic [XLEN-1:0] o_res;
  logic            o_illegal;
  logic            o_stall;

  int tests = 0;
  int fails = 0;

  ex_mdu #(.XLEN(XLEN)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_f3      (i_f3),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_kill    (i_kill),
    .o_valid   (o_valid),
    .o_res     (o_res),
    .o_illegal (o_illegal),
    .o_stall   (o_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: result, illegal flag and cycles from acceptance to strobe.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ill, output int lat);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    bit ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    lat = 33;
    ill = 1'b0;
    r = '0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) begin r = '1; lat = 1; end
            else if (ovf) begin r = a; lat = 1; end
            else r = ia / ib;
      3'd5: if (b == 0) begin r = '1; lat = 1; end
            else r = a / b;
      3'd6: if (b == 0) begin r = a; lat = 1; end
            else if (ovf) begin r = '0; lat = 1; end
            else r = ia % ib;
      default: if (b == 0) begin r = a; lat = 1; end
               else r = a % b;
    endcase
`ifndef ARVI_MDU_DIV_EN
    if (f3[2]) begin
      r = '0;
      ill = 1'b1;
      lat = 1;
    end
`endif
  endtask

  // Issue one op from IDLE, scramble the inputs right after acceptance and
  // check strobe timing, result, flag and post-strobe hold.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ei, input int el);
    int cyc;
    check({tag, " ready"}, 64'(o_ready), 64'(1));
    i_valid = 1'b1;
    i_f3    = f3;
    i_rs1   = a;
    i_rs2   = b;
    i_kill  = 1'b0;
    #1;
    check({tag, " stall"}, 64'(o_stall), 64'(1));
    tick();
    i_valid = 1'b0;
    i_f3    = 3'($urandom);
    i_rs1   = $urandom;
    i_rs2   = $urandom;
    check({tag, " busy"}, 64'(o_ready), 64'(0));
    cyc = 1;
    while (o_valid !== 1'b1 && cyc <= MAX_WAIT) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(el));
    check({tag, " res"}, 64'(o_res), 64'(er));
    check({tag, " illegal"}, 64'(o_illegal), 64'(ei));
    tick();
    check({tag, " strobe once"}, 64'(o_valid), 64'(0));
    check({tag, " hold"}, 64'(o_res), 64'(er));
  endtask

  task automatic run_model(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b);
    logic [31:0] er;
    logic ei;
    int el;
    model(f3, a, b, er, ei, el);
    run_op(tag, f3, a, b, er, ei, el);
  endtask

  // Divide-class directed case: constants from the op table when the
  // divider is built, illegal completion otherwise.
  task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int el);
`ifdef ARVI_MDU_DIV_EN
    run_op(tag, f3, a, b, er, 1'b0, el);
`else
    run_op(tag, f3, a, b, 32'h0, 1'b1, 1);
`endif
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prior;
    int seen;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_kill  = 1'b0;
    i_f3    = '0;
    i_rs1   = '0;
    i_rs2   = '0;
    repeat (3) tick();
    check("reset ready", 64'(o_ready), 64'(1));
    check("reset valid", 64'(o_valid), 64'(0));
    check("reset res", 64'(o_res), 64'(0));
    check("reset illegal", 64'(o_illegal), 64'(0));
    i_rst = 1'b1;
    tick();

    run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
    run_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_div("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_div("divu 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_div("remu 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_div("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_div("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_div("div 9/3", 3'd4, 32'd9, 32'd3, 32'd3, 33);

    // Flush in BUSY cycle 10.
    prior = o_res;
    i_valid = 1'b1; i_f3 = 3'd0; i_rs1 = 32'd11; i_rs2 = 32'd13;
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    check("kill ready", 64'(o_ready), 64'(1));
    check("kill res kept", 64'(o_res), 64'(prior));
    seen = 0;
    repeat (MAX_WAIT) begin
      if (o_valid === 1'b1) seen++;
      tick();
    end
    check("kill no strobe", 64'(seen), 64'(0));
    run_op("mul 3*4 after kill", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 33);

    // Flush while in DONE: strobe hidden, old result kept.
    prior = o_res;
    i_valid = 1'b1; i_f3 = 3'd5; i_rs1 = 32'd77; i_rs2 = 32'd0;
    tick();
    i_valid = 1'b0;
    i_kill = 1'b1;
    #1;
    check("kill done valid", 64'(o_valid), 64'(0));
    check("kill done res", 64'(o_res), 64'(prior));
    tick();
    i_kill = 1'b0;
    check("kill done ready", 64'(o_ready), 64'(1));
    check("kill done res after", 64'(o_res), 64'(prior));

    // Kill together with valid in IDLE is not an acceptance.
    i_valid = 1'b1; i_kill = 1'b1; i_f3 = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd5;
    tick();
    i_valid = 1'b0; i_kill = 1'b0;
    check("kill+valid ready", 64'(o_ready), 64'(1));
    seen = 0;
    repeat (MAX_WAIT) begin
      if (o_valid === 1'b1) seen++;
      tick();
    end
    check("kill+valid no strobe", 64'(seen), 64'(0));

    // Reset in BUSY cycle 5 overrides everything, including a live request.
    i_valid = 1'b1; i_f3 = 3'd1; i_rs1 = 32'd1234; i_rs2 = 32'd5678;
    tick();
    repeat (4) tick();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    i_valid = 1'b0;
    check("rst mid ready", 64'(o_ready), 64'(1));
    check("rst mid res", 64'(o_res), 64'(0));
    seen = 0;
    repeat (MAX_WAIT) begin
      if (o_valid === 1'b1) seen++;
      tick();
    end
    check("rst mid no strobe", 64'(seen), 64'(0));

    for (int i = 0; i < 40; i++) begin
      run_model($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; SHALL be even and at least 8.
REQ-002 i_clk  input  1  clock; reset i_rst, synchronous, active-low; clock i_clk.
REQ-003 i_rst  input  1  synchronous active-low reset.
REQ-004 i_valid  input  1  operation request from EX stage.
REQ-005 o_ready  output  1  block is idle and can accept a request.
REQ-006 i_f3  input  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 i_rs1, i_rs2  input  XLEN  operands.
REQ-008 i_kill  input  1  pipeline flush; abandons any operation.
REQ-009 o_valid  output  1  one-cycle result strobe.
REQ-010 o_res  output  XLEN  result; holds its value until the next o_valid.
REQ-011 o_illegal  output  1  op not supported in this build; qualified by o_valid.
REQ-012 o_stall  output  1  i_valid && !o_valid (combinational); EX-stage hold request.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; o_ready SHALL be 1 only in IDLE.
REQ-014 Accept: i_valid && o_ready && !i_kill at edge T latches i_f3, operands and signs; the FSM then enters BUSY, or enters DONE for the fast paths.
REQ-015 Latency: BUSY lasts exactly XLEN cycles, with an iteration counter of width clog2(XLEN)+1; DONE is cycle T+XLEN+1, and o_valid=1 only in DONE.
REQ-016 Multiply: shift-add, 1 bit/cycle, on the 2*XLEN product; MUL returns the low half, and MULH, MULHSU and MULHU return the high half.
REQ-017 Signedness: MULH uses signed×signed, MULHSU uses signed rs1 × unsigned rs2, MULHU uses unsigned×unsigned.
REQ-018 Divide: restoring, 1 quotient bit/cycle on magnitudes.
REQ-019 Sign fix for signed division: quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-020 Fast path, divide by zero (rs2==0): DONE at T+1. Quotient = all ones; remainder = rs1.
REQ-021 Fast path, signed overflow (DIV/REM, rs1==-2^(XLEN-1), rs2==-1): DONE at T+1. Quotient = rs1; remainder = 0.
REQ-022 DONE always returns to IDLE on the next edge; there is no back-to-back acceptance from DONE.
REQ-023 i_kill in BUSY or DONE: next state IDLE, o_valid suppressed, o_res unchanged.
REQ-024 i_kill together with i_valid in IDLE: request not accepted.
REQ-025 Changes to i_rs1, i_rs2 or i_f3 after acceptance SHALL NOT affect the result.

Reset
REQ-026 While i_rst==0 at the clock edge: state IDLE, counter 0, o_res 0, o_valid 0, o_illegal 0.
REQ-027 Reset takes priority over i_kill and i_valid, including mid-operation.

Configuration
REQ-028 Macro ARVI_MDU_DIV_EN; defined: all eight ops supported as above.
REQ-029 Undefined: divider datapath absent; i_f3[2]==1 requests complete at T+1 with o_valid=1, o_illegal=1, o_res=0.
REQ-030 Undefined: multiply behaviour is unchanged.

Structure
REQ-031 Package arvi_mdu_pkg: FSM state enum, funct3 localparams, op-class helper function (is_div, is_signed_a, is_signed_b).
REQ-032 Sub-module mdu_divstep: one combinational restoring-divide step (XLEN parameter); instantiated only under ARVI_MDU_DIV_EN.
REQ-033 Target 120–400 RTL lines, excluding the package.

Verification (XLEN=32)
REQ-034 MUL, rs1=7, rs2=0xFFFFFFFD, accepted at T -> o_valid at T+33 only, o_res=0xFFFFFFEB, o_illegal=0.
REQ-035 MULH 0x80000000×0x80000000 -> 0x40000000.
REQ-036 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-038 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD at T+33.
REQ-039 REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
REQ-040 DIVU 5/0 -> 0xFFFFFFFF at T+1.
REQ-041 REMU 5/0 -> 5 at T+1.
REQ-042 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1.
REQ-043 i_kill at BUSY cycle 10 -> no o_valid, o_ready=1 next cycle, o_res keeps the prior value; a following MUL 3×4 -> 12.
REQ-044 i_rst=0 at BUSY cycle 5 -> IDLE, o_res=0, no o_valid.
REQ-045 Operands changed after acceptance -> result unaffected.
REQ-046 ARVI_MDU_DIV_EN undefined, DIV 9/3 -> o_valid at T+1, o_illegal=1, o_res=0; MUL still correct.
